// File: rtl/pipe_pkg.sv
// Shared types and default widths for the inter-stage pipeline registers.
package pipe_pkg;

    // Occupancy of a skid-buffered stage: nothing, main register only, main + skid entry.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } stage_state_e;

    // EX/MEM word as packed by the caller; MSB first.
    typedef struct packed {
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic [31:0] rs2_data;
        logic [31:0] alu_result;
    } ex_mem_t;

    localparam int unsigned DATA_W_DEFAULT = $bits(ex_mem_t);
    localparam int unsigned SKID_DEFAULT   = 1;
    localparam int unsigned CNT_W_DEFAULT  = 16;

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, optional
// 2-entry skid buffer and a saturating stall-cycle counter. The payload is opaque.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned SKID   = SKID_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic             up_xfer;
    logic             dn_xfer;
    logic [CNT_W-1:0] stall_cnt_q;

    assign up_xfer = in_valid & in_ready;
    assign dn_xfer = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            stage_state_e      state_q;
            logic [DATA_W-1:0] m_q;
            logic [DATA_W-1:0] s_q;
            logic              rdy_q;

            // Occupancy FSM; rdy_q mirrors "skid entry not full" one cycle ahead so
            // in_ready never depends on out_ready.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    // Both leave an all-zero bubble; a word accepted now is dropped.
                    state_q <= ST_EMPTY;
                    m_q     <= '0;
                    s_q     <= '0;
                    rdy_q   <= 1'b1;
                end else begin
                    unique case (state_q)
                        ST_EMPTY: begin
                            if (up_xfer) begin
                                m_q     <= in_data;
                                state_q <= ST_FULL;
                            end
                        end
                        ST_FULL: begin
                            if (up_xfer && dn_xfer) begin
                                m_q <= in_data;
                            end else if (up_xfer) begin
                                s_q     <= in_data;
                                state_q <= ST_SKID;
                                rdy_q   <= 1'b0;
                            end else if (dn_xfer) begin
                                state_q <= ST_EMPTY;
                            end
                        end
                        ST_SKID: begin
                            if (dn_xfer) begin
                                m_q     <= s_q;
                                state_q <= ST_FULL;
                                rdy_q   <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_EMPTY;
                            rdy_q   <= 1'b1;
                        end
                    endcase
                end
            end

            assign out_valid = (state_q != ST_EMPTY);
            assign out_data  = m_q;
            assign in_ready  = rdy_q & ~reset;
        end else begin : g_noskid
            logic              valid_q;
            logic [DATA_W-1:0] m_q;

            // Single register: refill in the same cycle the old word drains.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    valid_q <= 1'b0;
                    m_q     <= '0;
                end else if (up_xfer) begin
                    valid_q <= 1'b1;
                    m_q     <= in_data;
                end else if (dn_xfer) begin
                    valid_q <= 1'b0;
                end
            end

            assign out_valid = valid_q;
            assign out_data  = m_q;
            assign in_ready  = ~reset & (~valid_q | out_ready);
        end
    endgenerate

    // Saturating count of stalled cycles; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid variant (a_*), single-register variant (b_*), 4-bit counter (c_*).
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DUT A: SKID=1, full EX/MEM width
    logic        a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [75:0] a_in_data, a_out_data;
    logic [15:0] a_stall_cnt;

    // DUT B: SKID=0
    logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [7:0]  b_in_data, b_out_data;
    logic [15:0] b_stall_cnt;

    // DUT C: SKID=1, CNT_W=4
    logic        c_reset, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
    logic [7:0]  c_in_data, c_out_data;
    logic [3:0]  c_stall_cnt;

    pipe_stage_reg #(.DATA_W(76), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .flush(a_flush), .stall_cnt(a_stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .flush(b_flush), .stall_cnt(b_stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .SKID(1), .CNT_W(4)) u_c (
        .clk(clk), .reset(c_reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .flush(c_flush), .stall_cnt(c_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_reset = 1; a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_flush = 0;
        b_reset = 1; b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_flush = 0;
        c_reset = 1; c_in_valid = 0; c_in_data = '0; c_out_ready = 0; c_flush = 0;
        tick();
        #1;
        check("a_rdy_in_reset", a_in_ready, 0);
        check("b_rdy_in_reset", b_in_ready, 0);
        a_reset = 0; b_reset = 0; c_reset = 0;
        #1;
        check("a_rst_valid", a_out_valid, 0);
        check("a_rst_data", a_out_data, 0);
        check("a_rst_cnt", a_stall_cnt, 0);
        check("a_rst_rdy", a_in_ready, 1);
        check("b_rst_rdy", b_in_ready, 1);

        // Reset mid-stream: fill to SKID with A, B
        a_in_valid = 1; a_in_data = 76'hA;
        tick();
        check("a_mid_fill_a", a_out_data, 76'hA);
        a_in_data = 76'hB;
        tick();
        check("a_mid_skid_rdy", a_in_ready, 0);
        check("a_mid_cnt1", a_stall_cnt, 1);
        a_reset = 1; a_in_valid = 0; a_out_ready = 1;
        tick();
        a_reset = 0;
        #1;
        check("a_mid_rst_valid", a_out_valid, 0);
        check("a_mid_rst_data", a_out_data, 0);
        check("a_mid_rst_cnt", a_stall_cnt, 0);
        check("a_mid_rst_rdy", a_in_ready, 1);
        tick();
        check("a_mid_no_b", a_out_valid, 0);

        // Streaming 1..8 with out_ready=1
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1; a_in_data = 76'(i);
            #1;
            check("a_str_rdy", a_in_ready, 1);
            tick();
            check("a_str_valid", a_out_valid, 1);
            check("a_str_data", a_out_data, 128'(i));
        end
        a_in_valid = 0;
        tick();
        check("a_str_drain", a_out_valid, 0);

        // Back-pressure with skid
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 76'h11;
        tick();
        check("a_bp_11", a_out_data, 76'h11);
        check("a_bp_rdy_full", a_in_ready, 1);
        a_in_data = 76'h22;
        tick();
        check("a_bp_rdy_skid", a_in_ready, 0);
        check("a_bp_hold_11", a_out_data, 76'h11);
        a_in_data = 76'h33;
        for (int i = 0; i < 4; i++) tick();
        check("a_bp_cnt5", a_stall_cnt, 5);
        check("a_bp_still_11", a_out_data, 76'h11);
        check("a_bp_still_rdy0", a_in_ready, 0);
        a_out_ready = 1;
        tick();
        check("a_bp_out_22", a_out_data, 76'h22);
        check("a_bp_rdy_back", a_in_ready, 1);
        tick();
        check("a_bp_out_33", a_out_data, 76'h33);
        check("a_bp_valid_33", a_out_valid, 1);
        a_in_valid = 0;
        tick();
        check("a_bp_empty", a_out_valid, 0);
        check("a_bp_cnt_kept", a_stall_cnt, 5);

        // Flush while stalled with 0x66 offered
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 76'h55;
        tick();
        a_in_valid = 0;
        tick();
        check("a_fl_held_55", a_out_data, 76'h55);
        a_flush = 1; a_in_valid = 1; a_in_data = 76'h66;
        #1;
        check("a_fl_rdy", a_in_ready, 1);
        tick();
        a_flush = 0; a_in_valid = 0;
        #1;
        check("a_fl_valid", a_out_valid, 0);
        check("a_fl_data", a_out_data, 0);
        check("a_fl_cnt", a_stall_cnt, 7);
        a_out_ready = 1;
        tick();
        check("a_fl_no_66", a_out_valid, 0);

        // SKID=0: combinational in_ready, replace in one cycle
        b_in_valid = 1; b_in_data = 8'h5A;
        #1;
        check("b_rdy_empty", b_in_ready, 1);
        tick();
        check("b_valid", b_out_valid, 1);
        check("b_rdy_stall", b_in_ready, 0);
        b_in_data = 8'h6B;
        tick();
        check("b_hold_5a", b_out_data, 8'h5A);
        b_out_ready = 1;
        #1;
        check("b_rdy_comb", b_in_ready, 1);
        tick();
        check("b_replace", b_out_data, 8'h6B);
        check("b_replace_valid", b_out_valid, 1);
        b_in_valid = 0;
        tick();
        check("b_drain", b_out_valid, 0);

        // Counter saturation with CNT_W=4
        c_in_valid = 1; c_in_data = 8'h77;
        tick();
        c_in_valid = 0;
        for (int i = 0; i < 10; i++) tick();
        check("c_cnt10", c_stall_cnt, 10);
        for (int i = 0; i < 10; i++) tick();
        check("c_cnt_sat", c_stall_cnt, 15);
        for (int i = 0; i < 3; i++) tick();
        check("c_cnt_hold", c_stall_cnt, 15);
        check("c_data_hold", c_out_data, 8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
